control_pipe: RTL and testbench
===============================

// Module: control_pipe
// PURPOSE
//  Pipelined main control for the 5-stage MIPS core. Decodes the ID-stage opcode
//  into the control bundle and carries it through ID/EX, EX/MEM and MEM/WB
//  registers, so every stage reads its own fields. Adds load-use and
//  branch-operand hazard detection (stall + bubble) and branch/jump IF flush.
//  Sits between the IF/ID register and the datapath stage muxes.
// PARAMETERS
//  OP_W     6  opcode width
//  REG_W    5  register-address width
//  ALUOP_W  2  ALUOp field width; codes zero-extended when ALUOP_W > 2
// PORTS
//  clk_i        in   1        clock
//  rst_i        in   1        synchronous, active-high reset
//  valid_i      in   1        IF/ID holds a real instruction
//  Op_i         in   OP_W     ID-stage opcode
//  Rs_i         in   REG_W    ID-stage rs
//  Rt_i         in   REG_W    ID-stage rt
//  Rd_i         in   REG_W    ID-stage rd
//  BranchEq_i   in   1        ID-stage register compare: rs == rt
//  Stall_o      out  1        hold PC and IF/ID this cycle (combinational)
//  Flush_o      out  1        squash IF/ID contents this cycle (combinational)
//  Jump_o       out  1        ID holds a jump (combinational)
//  ex_RegDst_o  out  1        EX-stage field
//  ex_ALUSrc_o  out  1        EX-stage field
//  ex_ALUOp_o   out  ALUOP_W  EX-stage field
//  mem_MemRead_o  out  1      MEM-stage field
//  mem_MemWrite_o out  1      MEM-stage field
//  wb_RegWrite_o  out  1      WB-stage field
//  wb_MemtoReg_o  out  1      WB-stage field
//  Illegal_o    out  1        one-cycle pulse: unknown opcode entered EX
// BEHAVIOUR
//  - Decode table (RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp, ALUSrc):
//    000000 R: 1 0 0 0 0 1 11 0 | 001000 addi: 1 0 0 0 0 0 00 1 | 100011 lw: 1 1 0 1 0 0 00 1
//    101011 sw: 0 0 0 0 1 0 00 1 | 000100 beq: 0 0 1 0 0 0 01 0 | 000010 j: all 0, Jump_o=1
//  - Any other opcode: all-zero bundle. Illegal_o asserts on the cycle that bundle is in EX.
//  - valid_i=0: all-zero bundle, with no hazard, flush or illegal detection.
//  - Pipeline advances every cycle. Each stage register loads the previous stage every cycle.
//  - On Stall_o, ID/EX loads an all-zero bundle (bubble). Latency ID->EX, EX->MEM, MEM->WB = 1 cycle each.
//  - ID/EX also stores dest = RegDst ? Rd_i : Rt_i. EX/MEM also stores dest, RegWrite and MemRead.
//  - Load-use stall: ID/EX MemRead & dest!=0 & (dest==Rs_i | dest==Rt_i); exactly 1 cycle.
//  - beq operand stall: ID is beq and either condition below, with dest!=0 and dest equal to Rs_i or Rt_i:
//    (a) ID/EX RegWrite: 1 cycle; for an ID/EX lw, 2 cycles total.
//    (b) EX/MEM MemRead: 1 cycle.
//  - Flush_o = valid_i & ~Stall_o & ((beq & BranchEq_i) | jump). Stall has priority; Flush_o=0 while stalling.
//  - Stall and flush are computed only from the current ID and the stage registers, never from older state.
//  - Reset: all stage registers cleared. Every registered output and Illegal_o = 0 in the cycle after rst_i.
//    Stall_o, Flush_o and Jump_o depend on valid_i.
//  - Reset mid-stall: the hazard is dropped. The next instruction is re-evaluated against empty stages.
//  - Register $0 as dest never causes a stall.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: adds output ports StallCnt_o[15:0] and FlushCnt_o[15:0].
//    Each increments once per cycle its signal is high, saturates at 16'hFFFF, and clears on rst_i.
//  Undefined: those ports and their counters do not exist. All other behaviour is identical.
// TESTING
//  1 lw $2,0($1) then add $3,$2,$4 -> Stall_o=1 for one cycle; a bubble (all-0) in EX;
//    add reaches EX one cycle later with ex_RegDst_o=1 and ex_ALUOp_o=2'b11.
//  2 lw $2 then beq $2,$5 -> Stall_o=1 for 2 cycles, then Flush_o=BranchEq_i.
//    Also addi $2 then beq $2,$0 -> exactly 1 stall cycle.
//  3 beq with BranchEq_i=1 and no hazard -> Flush_o=1 same cycle. j -> Jump_o=1 and Flush_o=1.
//  4 Op_i=6'b111111 -> next cycle Illegal_o=1 for one cycle and the EX/MEM/WB bundle is all 0.
//  5 lw $0 followed by add $3,$0,$0 -> no stall.
//    rst_i asserted during a stall cycle -> next cycle every output=0 and no residual stall.
//  6 CTRL_PERF_CNT_EN: 3 load-use hazards plus 2 taken beq -> StallCnt_o=3, FlushCnt_o=2.
//    Forcing 70000 stall cycles -> StallCnt_o holds 16'hFFFF.

Source files
------------

// File: rtl/control_pipe.sv
// ---------------------------------------------------------------------------
// control_pipe
//   Pipelined main control for a 5-stage MIPS core. It decodes the ID-stage
//   opcode into a control bundle and carries that bundle through the ID/EX,
//   EX/MEM and MEM/WB registers, so each stage reads its own fields. It also
//   detects two hazards and flushes IF after a taken branch or a jump:
//     - load-use hazard: stall for one cycle and insert a bubble
//     - beq operand hazard: stall until the beq source operands are ready
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   valid_i                 IF/ID holds a real instruction
//   Op_i, Rs_i, Rt_i, Rd_i  ID-stage opcode and register fields
//   BranchEq_i              ID-stage register compare result (rs == rt)
//   Stall_o                 hold PC and IF/ID (combinational)
//   Flush_o                 squash IF/ID (combinational)
//   Jump_o                  ID holds a jump (combinational)
//   ex_*                    EX-stage control fields
//   mem_*                   MEM-stage control fields
//   wb_*                    WB-stage control fields
//   Illegal_o               high for the one cycle an unknown opcode is in EX
//
// Optional feature
//   CTRL_PERF_CNT_EN  adds the StallCnt_o and FlushCnt_o outputs. These are
//                     16-bit saturating counts of the cycles in which Stall_o
//                     and Flush_o are high.
// ---------------------------------------------------------------------------
module control_pipe #(
    parameter int OP_W    = 6,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [OP_W-1:0]    Op_i,
    input  logic [REG_W-1:0]   Rs_i,
    input  logic [REG_W-1:0]   Rt_i,
    input  logic [REG_W-1:0]   Rd_i,
    input  logic               BranchEq_i,
    output logic               Stall_o,
    output logic               Flush_o,
    output logic               Jump_o,
    output logic               ex_RegDst_o,
    output logic               ex_ALUSrc_o,
    output logic [ALUOP_W-1:0] ex_ALUOp_o,
    output logic               mem_MemRead_o,
    output logic               mem_MemWrite_o,
    output logic               wb_RegWrite_o,
    output logic               wb_MemtoReg_o,
    output logic               Illegal_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0]        StallCnt_o,
    output logic [15:0]        FlushCnt_o
`endif
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal;
    } ctrl_t;

    ctrl_t              id_ctrl;
    logic               id_branch;
    logic               id_jump;
    logic [REG_W-1:0]   id_dest;

    ctrl_t              idex_ctrl;
    logic [REG_W-1:0]   idex_dest;
    logic               exmem_reg_write;
    logic               exmem_mem_to_reg;
    logic               exmem_mem_read;
    logic               exmem_mem_write;
    logic [REG_W-1:0]   exmem_dest;
    logic               memwb_reg_write;
    logic               memwb_mem_to_reg;

    logic               idex_hit;
    logic               exmem_hit;
    logic               load_use;
    logic               beq_hazard;
    logic               stall;
    logic               flush;

    // Decode. An invalid slot decodes to an all-zero bundle. Such a slot
    // therefore never raises a hazard, a flush or an illegal flag.
    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        id_ctrl   = '0;
        id_branch = 1'b0;
        id_jump   = 1'b0;
        if (valid_i) begin
            case (Op_i)
                OP_RTYPE: begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.reg_dst   = 1'b1;
                    id_ctrl.alu_op    = ALUOP_W'(2'b11);
                end
                OP_ADDI: begin
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.alu_src   = 1'b1;
                end
                OP_LW: begin
                    id_ctrl.reg_write  = 1'b1;
                    id_ctrl.mem_to_reg = 1'b1;
                    id_ctrl.mem_read   = 1'b1;
                    id_ctrl.alu_src    = 1'b1;
                end
                OP_SW: begin
                    id_ctrl.mem_write = 1'b1;
                    id_ctrl.alu_src   = 1'b1;
                end
                OP_BEQ: begin
                    id_branch      = 1'b1;
                    id_ctrl.alu_op = ALUOP_W'(2'b01);
                end
                OP_J:    id_jump         = 1'b1;
                default: id_ctrl.illegal = 1'b1;
            endcase
        end
    end

    assign id_dest = id_ctrl.reg_dst ? Rd_i : Rt_i;

    // A stage only creates a hazard when it writes a non-zero register that
    // the ID-stage instruction reads. Register $0 never causes a stall.
    assign idex_hit  = (idex_dest  != '0) && (idex_dest  == Rs_i || idex_dest  == Rt_i);
    assign exmem_hit = (exmem_dest != '0) && (exmem_dest == Rs_i || exmem_dest == Rt_i);

    assign load_use = idex_ctrl.mem_read & idex_hit;
    // beq resolves in ID, so it also waits on an ALU result still in EX. It
    // also waits on a load still in MEM. This gives two stall cycles behind
    // a lw.
    assign beq_hazard = id_branch &
                        ((idex_ctrl.reg_write & idex_hit) | (exmem_mem_read & exmem_hit));

    assign stall = valid_i & (load_use | beq_hazard);
    assign flush = valid_i & ~stall & ((id_branch & BranchEq_i) | id_jump);

    assign Stall_o = stall;
    assign Flush_o = flush;
    assign Jump_o  = id_jump;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // register samples the previous stage's pre-edge value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_ctrl        <= '0;
            idex_dest        <= '0;
            exmem_reg_write  <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_mem_read   <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_dest       <= '0;
            memwb_reg_write  <= 1'b0;
            memwb_mem_to_reg <= 1'b0;
        end else begin
            // While stalled, the ID instruction stays put and EX gets a bubble.
            idex_ctrl        <= stall ? '0 : id_ctrl;
            idex_dest        <= stall ? '0 : id_dest;
            exmem_reg_write  <= idex_ctrl.reg_write;
            exmem_mem_to_reg <= idex_ctrl.mem_to_reg;
            exmem_mem_read   <= idex_ctrl.mem_read;
            exmem_mem_write  <= idex_ctrl.mem_write;
            exmem_dest       <= idex_dest;
            memwb_reg_write  <= exmem_reg_write;
            memwb_mem_to_reg <= exmem_mem_to_reg;
        end
    end

    assign ex_RegDst_o    = idex_ctrl.reg_dst;
    assign ex_ALUSrc_o    = idex_ctrl.alu_src;
    assign ex_ALUOp_o     = idex_ctrl.alu_op;
    assign Illegal_o      = idex_ctrl.illegal;
    assign mem_MemRead_o  = exmem_mem_read;
    assign mem_MemWrite_o = exmem_mem_write;
    assign wb_RegWrite_o  = memwb_reg_write;
    assign wb_MemtoReg_o  = memwb_mem_to_reg;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            StallCnt_o <= '0;
            FlushCnt_o <= '0;
        end else begin
            if (stall && StallCnt_o != 16'hFFFF) StallCnt_o <= StallCnt_o + 16'd1;
            if (flush && FlushCnt_o != 16'hFFFF) FlushCnt_o <= FlushCnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Directed testbench for control_pipe. Expected values are worked out by hand
// from the decode table and the hazard rules.
module tb_control_pipe;

    localparam logic [5:0] R_OP = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [5:0] op = '0;
    logic [4:0] rs = '0, rt = '0, rd = '0;
    logic       beq_eq = 1'b0;

    logic       stall_o, flush_o, jump_o;
    logic       ex_regdst, ex_alusrc;
    logic [1:0] ex_aluop;
    logic       mem_rd, mem_wr, wb_rw, wb_m2r, illegal;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_pipe dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_i       (valid),
        .Op_i          (op),
        .Rs_i          (rs),
        .Rt_i          (rt),
        .Rd_i          (rd),
        .BranchEq_i    (beq_eq),
        .Stall_o       (stall_o),
        .Flush_o       (flush_o),
        .Jump_o        (jump_o),
        .ex_RegDst_o   (ex_regdst),
        .ex_ALUSrc_o   (ex_alusrc),
        .ex_ALUOp_o    (ex_aluop),
        .mem_MemRead_o (mem_rd),
        .mem_MemWrite_o(mem_wr),
        .wb_RegWrite_o (wb_rw),
        .wb_MemtoReg_o (wb_m2r),
        .Illegal_o     (illegal)
`ifdef CTRL_PERF_CNT_EN
        ,
        .StallCnt_o    (stall_cnt),
        .FlushCnt_o    (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then sample away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic v, input logic [5:0] o, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic eq);
        valid = v; op = o; rs = s; rt = t; rd = d; beq_eq = eq;
        #1;
    endtask

    task automatic drain();
        id(1'b0, R_OP, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) tick();
    endtask

    // Returns {RegDst, ALUSrc, ALUOp}.
    function automatic logic [3:0] ex_vec();
        return {ex_regdst, ex_alusrc, ex_aluop};
    endfunction

    // Returns {MemRead, MemWrite, RegWrite, MemtoReg, Illegal}.
    function automatic logic [4:0] late_vec();
        return {mem_rd, mem_wr, wb_rw, wb_m2r, illegal};
    endfunction

    initial begin
        // Reset
        repeat (2) tick();
        rst = 1'b0;
        check("reset_ex", {28'd0, ex_vec()}, 32'h0);
        check("reset_late", {27'd0, late_vec()}, 32'h0);
        check("reset_comb", {29'd0, stall_o, flush_o, jump_o}, 32'h0);

        // 1: lw $2,0($1) then add $3,$2,$4 -> one-cycle load-use stall
        id(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        check("lw_no_stall", {31'd0, stall_o}, 32'h0);
        tick();
        check("lw_in_ex", {28'd0, ex_vec()}, 32'h4);
        id(1'b1, R_OP, 5'd2, 5'd4, 5'd3, 1'b0);
        check("lu_stall", {30'd0, stall_o, flush_o}, 32'h2);
        tick();
        check("lu_bubble", {28'd0, ex_vec()}, 32'h0);
        check("lu_lw_mem", {31'd0, mem_rd}, 32'h1);
        check("lu_stall_done", {31'd0, stall_o}, 32'h0);
        tick();
        check("add_in_ex", {28'd0, ex_vec()}, 32'hB);
        check("add_mem_bubble", {31'd0, mem_rd}, 32'h0);
        check("lw_in_wb", {30'd0, wb_rw, wb_m2r}, 32'h3);
        drain();

        // 2a: lw $2 then beq $2,$5 -> two stall cycles, then Flush_o follows BranchEq_i
        id(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        id(1'b1, BEQ, 5'd2, 5'd5, 5'd0, 1'b1);
        check("beq_lw_stall1", {30'd0, stall_o, flush_o}, 32'h2);
        tick();
        check("beq_lw_stall2", {30'd0, stall_o, flush_o}, 32'h2);
        tick();
        check("beq_lw_release", {30'd0, stall_o, flush_o}, 32'h1);
        drain();

        // 2b: addi $2 then beq $2,$0 -> exactly one stall cycle
        id(1'b1, ADDI, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        check("addi_in_ex", {28'd0, ex_vec()}, 32'h4);
        id(1'b1, BEQ, 5'd2, 5'd0, 5'd0, 1'b0);
        check("beq_addi_stall", {31'd0, stall_o}, 32'h1);
        tick();
        check("beq_addi_release", {30'd0, stall_o, flush_o}, 32'h0);
        drain();

        // 3: taken beq with no hazard, not-taken beq, j, and j with valid_i=0
        id(1'b1, BEQ, 5'd6, 5'd7, 5'd0, 1'b1);
        check("beq_taken", {29'd0, stall_o, flush_o, jump_o}, 32'h2);
        id(1'b1, BEQ, 5'd6, 5'd7, 5'd0, 1'b0);
        check("beq_not_taken", {29'd0, stall_o, flush_o, jump_o}, 32'h0);
        tick();
        check("beq_in_ex", {28'd0, ex_vec()}, 32'h1);
        id(1'b1, J, 5'd0, 5'd0, 5'd0, 1'b0);
        check("jump", {29'd0, stall_o, flush_o, jump_o}, 32'h3);
        tick();
        check("jump_in_ex", {28'd0, ex_vec()}, 32'h0);
        id(1'b0, J, 5'd0, 5'd0, 5'd0, 1'b0);
        check("jump_invalid", {29'd0, stall_o, flush_o, jump_o}, 32'h0);
        drain();

        // sw flows through to MEM with MemWrite only
        id(1'b1, SW, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        check("sw_in_ex", {28'd0, ex_vec()}, 32'h4);
        id(1'b0, R_OP, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("sw_in_mem", {30'd0, mem_rd, mem_wr}, 32'h1);
        tick();
        check("sw_in_wb", {30'd0, wb_rw, wb_m2r}, 32'h0);
        drain();

        // 4: illegal opcode -> one-cycle Illegal_o pulse with an all-zero bundle
        id(1'b1, BAD, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("illegal_pulse", {27'd0, late_vec()}, 32'h1);
        check("illegal_ex", {28'd0, ex_vec()}, 32'h0);
        id(1'b0, R_OP, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("illegal_gone", {27'd0, late_vec()}, 32'h0);
        id(1'b0, BAD, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("illegal_invalid", {31'd0, illegal}, 32'h0);
        drain();

        // 5a: lw $0 then add $3,$0,$0 -> no stall
        id(1'b1, LW, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        id(1'b1, R_OP, 5'd0, 5'd0, 5'd3, 1'b0);
        check("reg0_no_stall", {31'd0, stall_o}, 32'h0);
        drain();

        // 5b: reset during a stall clears the pipe and drops the hazard
        id(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        id(1'b1, R_OP, 5'd2, 5'd4, 5'd3, 1'b0);
        check("pre_reset_stall", {31'd0, stall_o}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_ex", {28'd0, ex_vec()}, 32'h0);
        check("mid_reset_late", {27'd0, late_vec()}, 32'h0);
        check("mid_reset_no_stall", {31'd0, stall_o}, 32'h0);
        tick();
        check("post_reset_add", {28'd0, ex_vec()}, 32'hB);
        drain();

`ifdef CTRL_PERF_CNT_EN
        // 6: performance counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_reset", {stall_cnt, flush_cnt}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            id(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
            tick();
            id(1'b1, R_OP, 5'd2, 5'd4, 5'd3, 1'b0);
            tick();
            tick();
            drain();
        end
        for (int k = 0; k < 2; k++) begin
            id(1'b1, BEQ, 5'd6, 5'd7, 5'd0, 1'b1);
            tick();
            drain();
        end
        check("stall_cnt", {16'd0, stall_cnt}, 32'd3);
        check("flush_cnt", {16'd0, flush_cnt}, 32'd2);
        force dut.stall = 1'b1;
        repeat (70000) tick();
        release dut.stall;
        check("stall_cnt_sat", {16'd0, stall_cnt}, 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
